mem_responder: RTL and testbench

- Synchronous single-port 8-bit memory that answers `memory_if` transactions from the response side of the interface.
- Used as the target for the DMA copier and for other bus requesters, in RTL simulation and in synthesised test builds.
- Inserts a configurable wait latency before asserting `ready`, so requester handshakes are exercised under realistic stalls.
- Provides a combinational backdoor peek port and sticky error/statistics outputs for verification.

---
 rtl/mem_responder_if.sv | 20 ++
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// memory_if: request/response bus between a requester and a memory target.
//   ren, wen  : read / write request, held by the requester until ready
//   addr      : access address
//   wdata     : write data
//   rdata     : read data, valid only while ready=1
//   ready     : one-cycle completion strobe from the target
interface memory_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              ren;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (output ren, wen, addr, wdata, input rdata, ready);
   modport slave  (input ren, wen, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port memory target on memory_if with a fixed wait
// latency before ready, plus a backdoor peek port and sticky statistics.
//   CLK, nRST  : clock, synchronous active-low reset (also clears the memory)
//   memif      : memory_if slave side (ren, wen, addr, wdata -> rdata, ready)
//   peek_addr  : backdoor address
//   peek_data  : combinational mem[peek_addr]
//   error      : sticky, set when ren and wen are both seen in IDLE
//   rd_cnt     : completed reads, saturating
//   wr_cnt     : completed writes, saturating
module mem_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   memory_if.slave           memif,
   input  logic [ADDR_W-1:0] peek_addr,
   output logic [DATA_W-1:0] peek_data,
   output logic              error,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               op_wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rd_q;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               accept;
   logic               live;
   logic               commit_rd;
   logic               commit_wr;
   logic [ADDR_W-1:0]  cap_addr;

   // Exactly one of ren/wen starts a transfer; live tracks the latched op.
   assign accept   = memif.ren ^ memif.wen;
   assign live     = op_wr_q ? memif.wen : memif.ren;
   // With zero latency RESP is entered straight from IDLE, before addr_q holds the address.
   assign cap_addr = (state == IDLE) ? memif.addr : addr_q;
   assign peek_data = mem[peek_addr];

   // State register
   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and latency counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY > 0) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_W'(LATENCY - 1);
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (!live)            state_nxt = IDLE;
            else if (cnt == '0)   state_nxt = RESP;
            else                  cnt_nxt   = cnt - CNT_W'(1);
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Response outputs; a dropped request in RESP aborts without commit.
   always_comb begin
      memif.ready = 1'b0;
      memif.rdata = '0;
      commit_rd   = 1'b0;
      commit_wr   = 1'b0;
      if (nRST && state == RESP && live) begin
         memif.ready = 1'b1;
         commit_rd   = !op_wr_q;
         commit_wr   = op_wr_q;
         if (!op_wr_q) memif.rdata = rd_q;
      end
   end

   // Datapath: request latch, read capture, write commit, statistics
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt     <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         error   <= 1'b0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         mem     <= '{default: '0};
      end else begin
         cnt <= cnt_nxt;
         if (state == IDLE && accept) begin
            op_wr_q <= memif.wen;
            addr_q  <= memif.addr;
            wdata_q <= memif.wdata;
         end
         if (state == IDLE && memif.ren && memif.wen) error <= 1'b1;
         if (state_nxt == RESP && state != RESP) rd_q <= mem[cap_addr];
         if (commit_wr) mem[addr_q] <= wdata_q;
         if (commit_rd && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
         if (commit_wr && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with LATENCY=2.
module tb_mem_responder;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [ADDR_W-1:0] peek_addr;
   logic [DATA_W-1:0] peek_data;
   logic              error;
   logic [15:0]       rd_cnt;
   logic [15:0]       wr_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .memif     (bus.slave),
      .peek_addr (peek_addr),
      .peek_data (peek_data),
      .error     (error),
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.ren   = 1'b0;
      bus.wen   = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
   endtask

   // Tasks start and finish 1 time unit after a rising edge.
   task automatic do_reset();
      @(posedge CLK); #1;
      nRST = 1'b0;
      bus_idle();
      @(posedge CLK); @(posedge CLK); #1;
      nRST = 1'b1;
   endtask

   // One bus transfer; lat = cycles from request to ready (-1 on timeout).
   task automatic bus_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat);
      bus.ren   = !wr;
      bus.wen   = wr;
      bus.addr  = a;
      bus.wdata = d;
      lat = -1;
      rd  = '0;
      for (int n = 0; n < 50; n++) begin
         @(negedge CLK);
         if (bus.ready) begin
            lat = n;
            rd  = bus.rdata;
            break;
         end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      bus.ren = 1'b0;
      bus.wen = 1'b0;
   endtask

   task automatic watch_ready(input int n, output int hits);
      hits = 0;
      repeat (n) begin
         @(negedge CLK);
         if (bus.ready) hits++;
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      logic [7:0] rd;
      int         lat;
      int         hits;

      nRST      = 1'b0;
      peek_addr = '0;
      bus_idle();

      // Reset state
      do_reset();
      @(negedge CLK);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      @(posedge CLK); #1;

      // First read: ready three cycles after the request is first sampled
      bus_op(1'b0, 8'h10, 8'h00, rd, lat);
      check("rd0_latency", 32'(lat), 32'd3);
      check("rd0_rdata", 32'(rd), 32'h00);
      check("rd0_rd_cnt", 32'(rd_cnt), 32'd1);
      check("rd0_wr_cnt", 32'(wr_cnt), 32'd0);
      @(negedge CLK);
      check("rd0_strobe_one_cycle", 32'(bus.ready), 32'd0);
      check("rd0_rdata_idle", 32'(bus.rdata), 32'd0);
      @(posedge CLK); #1;

      // Write then read back
      do_reset();
      bus_op(1'b1, 8'h10, 8'hA5, rd, lat);
      check("wr1_latency", 32'(lat), 32'd3);
      bus_op(1'b0, 8'h10, 8'h00, rd, lat);
      check("raw_latency", 32'(lat), 32'd3);
      check("raw_rdata", 32'(rd), 32'hA5);
      peek_addr = 8'h10; #1;
      check("raw_peek", 32'(peek_data), 32'hA5);
      check("raw_wr_cnt", 32'(wr_cnt), 32'd1);
      check("raw_rd_cnt", 32'(rd_cnt), 32'd1);

      // ren and wen together: protocol error, no access
      do_reset();
      peek_addr = 8'h40;
      bus.ren = 1'b1; bus.wen = 1'b1; bus.addr = 8'h40; bus.wdata = 8'h77;
      @(posedge CLK); #1;
      bus_idle();
      watch_ready(6, hits);
      check("both_no_ready", 32'(hits), 32'd0);
      check("both_error_sticky", 32'(error), 32'd1);
      check("both_peek", 32'(peek_data), 32'h00);
      check("both_rd_cnt", 32'(rd_cnt), 32'd0);
      check("both_wr_cnt", 32'(wr_cnt), 32'd0);

      // Reset during WAIT of a write: no commit, everything back to reset values
      bus.wen = 1'b1; bus.addr = 8'h30; bus.wdata = 8'h99;
      @(posedge CLK); #1;
      nRST = 1'b0;
      @(negedge CLK);
      check("rstwait_ready", 32'(bus.ready), 32'd0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      bus_idle();
      peek_addr = 8'h30; #1;
      check("rstwait_peek30", 32'(peek_data), 32'h00);
      check("rstwait_error", 32'(error), 32'd0);
      check("rstwait_wr_cnt", 32'(wr_cnt), 32'd0);
      watch_ready(5, hits);
      check("rstwait_no_ready", 32'(hits), 32'd0);
      check("rstwait_peek30_late", 32'(peek_data), 32'h00);

      // Write request dropped during WAIT: aborted
      do_reset();
      bus.wen = 1'b1; bus.addr = 8'h20; bus.wdata = 8'h55;
      @(posedge CLK); #1;
      bus_idle();
      watch_ready(6, hits);
      check("abort_no_ready", 32'(hits), 32'd0);
      peek_addr = 8'h20; #1;
      check("abort_peek", 32'(peek_data), 32'h00);
      check("abort_wr_cnt", 32'(wr_cnt), 32'd0);
      bus_op(1'b0, 8'h20, 8'h00, rd, lat);
      check("abort_then_rd_latency", 32'(lat), 32'd3);
      check("abort_then_rd_data", 32'(rd), 32'h00);

      // Copier-style transfer: preload 0x00..0x03, copy to 0x80..0x83
      do_reset();
      for (int i = 0; i < 4; i++) bus_op(1'b1, 8'(i), 8'(i + 1), rd, lat);
      for (int i = 0; i < 4; i++) begin
         bus_op(1'b0, 8'(i), 8'h00, rd, lat);
         check("copy_src", 32'(rd), 32'(i + 1));
         bus_op(1'b1, 8'(8'h80 + i), rd, rd, lat);
      end
      for (int i = 0; i < 4; i++) begin
         peek_addr = 8'(8'h80 + i); #1;
         check("copy_dst", 32'(peek_data), 32'(i + 1));
      end
      check("copy_rd_cnt", 32'(rd_cnt), 32'd4);
      check("copy_wr_cnt_incl_preload", 32'(wr_cnt), 32'd8);

      // Held ren after completion is a fresh read: ready at cycles 3 and 7
      bus.ren = 1'b1; bus.addr = 8'h81;
      watch_ready(9, hits);
      bus_idle();
      check("held_ren_reads", 32'(hits), 32'd2);
      watch_ready(2, hits);
      check("held_ren_rd_cnt", 32'(rd_cnt), 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
